// File: rtl/apb_pkg.sv
// Shared types and address-map constants for the APB master bridge.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Upper half of the APB region base; the slave window index sits in [15:12].
    localparam logic [15:0] APB_BASE_HI   = 16'h1000;
    localparam int          SLAVE_IDX_LSB = 12;
    localparam int          SLAVE_IDX_MSB = 15;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a CPU byte address to an APB slave index (4 KB window per slave).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned IDX_W      = 2,
    parameter logic [31:0] APB_BASE   = {APB_BASE_HI, 16'h0000}
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    logic [3:0] win;
    logic       unused_offset;

    assign win           = addr[SLAVE_IDX_MSB:SLAVE_IDX_LSB];
    // The in-window byte offset plays no part in slave selection.
    assign unused_offset = ^addr[SLAVE_IDX_LSB-1:0];

    // A hit needs the region match and a window that has a populated slave.
    assign hit = (addr[31:16] == APB_BASE[31:16]) && (32'(win) < NUM_SLAVES);
    assign idx = IDX_W'(win);

endmodule

// File: rtl/apb_master_bridge.sv
// Turns single-word CPU load/store strobes into APB SETUP/ACCESS transfers.
// Latency: transfer c0, SETUP c1, ACCESS c2+, ready the cycle after PREADY (c3 with a zero-wait slave); decode miss answers at c1.
// Backpressure: busy is high in SETUP/ACCESS and transfer is dropped then; ACCESS stalls on PREADY up to TIMEOUT_CYCLES.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter logic [31:0] APB_BASE       = {APB_BASE_HI, 16'h0000},
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     transfer,
    input  logic                     write,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ready,
    output logic                     err,
    output logic                     busy,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [32*NUM_SLAVES-1:0] PRDATA_s,
    input  logic [NUM_SLAVES-1:0]    PREADY_s
);

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    apb_state_e                state_q, state_d;
    logic [31:0]               paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      penable_q, penable_d;
    logic [NUM_SLAVES-1:0]     psel_q, psel_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      ready_q, ready_d;
    logic                      err_q, err_d;
    logic                      busy_q, busy_d;

    logic                      dec_hit;
    logic [IDX_W-1:0]          dec_idx;
    logic [NUM_SLAVES-1:0][31:0] prdata_arr;
    logic                      sel_pready;
    logic [31:0]               sel_prdata;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .APB_BASE   (APB_BASE)
    ) u_dec (
        .addr (addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Only the latched slave's PREADY/PRDATA are ever looked at.
    assign prdata_arr = PRDATA_s;
    assign sel_pready = PREADY_s[idx_q];
    assign sel_prdata = prdata_arr[idx_q];

    // Next-state and next-output logic; ready/err default low so they pulse for one cycle.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        psel_d    = psel_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    if (dec_hit) begin
                        paddr_d         = addr;
                        pwdata_d        = wdata;
                        pwrite_d        = write;
                        idx_d           = dec_idx;
                        psel_d          = '0;
                        psel_d[dec_idx] = 1'b1;
                        busy_d          = 1'b1;
                        state_d         = SETUP;
                    end else begin
                        // Decode miss: answer with an error without touching the bus.
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_pready) begin
                    if (!pwrite_q) begin
                        rdata_d = sel_prdata;
                    end
                    ready_d   = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer without a ready pulse.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            psel_q    <= psel_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = penable_q;
    assign PSEL    = psel_q;
    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign busy    = busy_q;

endmodule
